// File: rtl/timer_counter_if.sv
// Peripheral bus port of the down-counting timer:
// register access plus the interrupt request line.
interface timer_counter_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    modport master (
        output addr,
        output we,
        output din,
        input  dout,
        input  irq
    );

    modport slave (
        input  addr,
        input  we,
        input  din,
        output dout,
        output irq
    );
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and
// auto-reload modes and a maskable sticky interrupt flag.
module timer_counter (
    input logic             clk,
    input logic             reset,
    timer_counter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    state_t      state, state_n;
    logic        en, en_n;
    logic [1:0]  mode, mode_n;
    logic        im, im_n;
    logic [31:0] preset, preset_n;
    logic [31:0] count, count_n;
    logic        flag, flag_n;
    logic        wr_ctrl, wr_pre;

    assign wr_ctrl = bus.we && (bus.addr == 2'b00);
    assign wr_pre  = bus.we && (bus.addr == 2'b01);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            en     <= 1'b0;
            mode   <= 2'b00;
            im     <= 1'b0;
            preset <= '0;
            count  <= '0;
            flag   <= 1'b0;
        end else begin
            state  <= state_n;
            en     <= en_n;
            mode   <= mode_n;
            im     <= im_n;
            preset <= preset_n;
            count  <= count_n;
            flag   <= flag_n;
        end
    end

    always_comb begin
        state_n  = state;
        en_n     = en;
        mode_n   = mode;
        im_n     = im;
        preset_n = preset;
        count_n  = count;
        flag_n   = flag;

        unique case (state)
            S_IDLE: begin
                if (en) state_n = S_LOAD;
            end
            S_LOAD: begin
                count_n = preset;
                state_n = S_CNT;
            end
            S_CNT: begin
                if (!en) begin
                    state_n = S_IDLE;
                end else if (count > 32'd1) begin
                    count_n = count - 32'd1;
                end else begin
                    count_n = '0;
                    flag_n  = 1'b1;
                    state_n = S_INT;
                end
            end
            S_INT: begin
                // Only MODE=01 reloads; 10/11 fall back to one-shot.
                if (mode == 2'b01) begin
                    flag_n  = 1'b0;
                    state_n = S_LOAD;
                end else begin
                    en_n    = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Software writes override the internal update of the same edge.
        if (wr_ctrl) begin
            en_n   = bus.din[0];
            mode_n = bus.din[2:1];
            im_n   = bus.din[3];
            flag_n = 1'b0;
        end
        if (wr_pre) begin
            preset_n = bus.din;
            flag_n   = 1'b0;
        end
    end

    always_comb begin
        bus.dout = '0;
        unique case (bus.addr)
            2'b00:   bus.dout = {28'd0, im, mode, en};
            2'b01:   bus.dout = preset;
            2'b10:   bus.dout = count;
            default: bus.dout = '0;
        endcase
    end

    assign bus.irq = flag & im;

endmodule

// File: tb/tb_timer_counter.sv
// Randomized and scenario stimulus for timer_counter, checked
// against a run-age model of the timer behaviour.
module tb_timer_counter;

    logic clk;
    logic reset;
    timer_counter_if bus ();

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: a run starts at the edge that sees EN in idle (age 0 =
    // load pending); age p in 1..lim counts, lim+1 is expiry.
    logic [31:0] m_pre, m_cnt, l_pre;
    logic        m_en, m_im, m_flag;
    logic [1:0]  m_mode;
    longint      age, lim;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, want %h",
                     tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pre = 0; m_cnt = 0; l_pre = 0;
        m_en = 0; m_im = 0; m_flag = 0;
        m_mode = 0; age = -1; lim = 1;
    endtask

    task automatic model_edge(input logic w,
                              input logic [1:0] a,
                              input logic [31:0] d);
        longint p;
        p = age;
        if (p < 0) begin
            if (m_en) age = 0;
        end else if (p == 0) begin
            l_pre = m_pre;
            lim   = (m_pre == 0) ? 1 : longint'(m_pre);
            m_cnt = m_pre;
            age   = 1;
        end else if (p <= lim) begin
            if (!m_en) begin
                age = -1;
            end else if (p < lim) begin
                m_cnt = l_pre - 32'(p);
                age   = p + 1;
            end else begin
                m_cnt  = 0;
                m_flag = 1;
                age    = p + 1;
            end
        end else begin
            if (m_mode == 2'b01) begin
                m_flag = 0;
                age    = 0;
            end else begin
                m_en = 0;
                age  = -1;
            end
        end
        if (w && a == 2'd0) begin
            {m_im, m_mode, m_en} = d[3:0];
            m_flag = 0;
        end
        if (w && a == 2'd1) begin
            m_pre  = d;
            m_flag = 0;
        end
    endtask

    function automatic logic [31:0] m_read(input int a);
        case (a)
            0:       return {28'd0, m_im, m_mode, m_en};
            1:       return m_pre;
            2:       return m_cnt;
            default: return 32'd0;
        endcase
    endfunction

    task automatic probe();
        for (int i = 0; i < 4; i++) begin
            bus.addr = i[1:0];
            #1;
            chk($sformatf("rd%0d", i), bus.dout, m_read(i));
        end
        chk("irq", {31'd0, bus.irq}, {31'd0, m_flag & m_im});
    endtask

    task automatic step(input logic w,
                        input logic [1:0] a,
                        input logic [31:0] d);
        @(negedge clk);
        bus.we = w; bus.addr = a; bus.din = d;
        @(posedge clk);
        model_edge(w, a, d);
        #1;
        bus.we = 1'b0;
        probe();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(1'b1, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'd0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        probe();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int guard;
        int r;
        reset = 1'b0;
        bus.we = 1'b0; bus.addr = 2'd0; bus.din = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        probe();
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        // One-shot, then software clear through a CTRL write.
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        idle(8);
        wr(2'd0, 32'h8);
        idle(2);

        // Auto-reload with interrupts unmasked.
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        idle(14);
        wr(2'd0, 32'h0);
        idle(3);

        // Masked expiry, then clear.
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h1);
        idle(5);
        wr(2'd0, 32'h8);
        idle(2);

        // Pause and resume.
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        guard = 0;
        while (!(age > 0 && m_cnt == 32'd6) && guard < 40) begin
            idle(1);
            guard++;
        end
        chk("pause_reach", 32'(guard < 40), 32'd1);
        wr(2'd0, 32'h0);
        idle(5);
        wr(2'd0, 32'h1);
        idle(4);

        // Bus edge cases.
        wr(2'd2, 32'hFFFF_FFFF);
        wr(2'd3, 32'hFFFF_FFFF);
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd0, 32'h0);
        idle(2);
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        idle(5);

        // Asynchronous reset in the middle of a count.
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        idle(6);
        async_reset();
        idle(3);

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 11);
            case (r)
                0: wr(2'd0, ($urandom_range(0, 7) == 0) ?
                            $urandom : ($urandom & 32'hF));
                1: wr(2'd1, 32'($urandom_range(0, 6)));
                2: wr(2'($urandom_range(2, 3)), $urandom);
                default: idle(1);
            endcase
            if (k == 300) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
